// File: rtl/morse_key_decoder.sv
// morse_key_decoder
// Single-key Morse decoder controller. Times key presses and releases with a
// built-in tick prescaler and a saturating duration counter. Presses are
// classified as dit, dash or backspace. Gaps are classified as intra-character,
// character end or word end. Tokens are handed out over a valid/ready interface.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   key        debounced key level, 1 = pressed
//   out_valid  token available (held until out_ready)
//   out_ready  consumer accepts the token
//   out_kind   0 = CHAR, 1 = SPACE, 2 = BACKSPACE, 3 = ERROR
//   out_len    symbol count for CHAR/ERROR, else 0
//   out_code   bit i = symbol i (bit0 sent first), 1 = dash
//   busy       controller is not idle
module morse_key_decoder #(
    parameter int TICK_DIV       = 50000,
    parameter int DASH_TICKS     = 200,
    parameter int BKSP_TICKS     = 1500,
    parameter int CHAR_GAP_TICKS = 300,
    parameter int WORD_GAP_TICKS = 700,
    parameter int MAX_SYMS       = 6,
    parameter int CNT_W          = 12
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              key,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [1:0]                        out_kind,
    output logic [$clog2(MAX_SYMS+1)-1:0]     out_len,
    output logic [MAX_SYMS-1:0]               out_code,
    output logic                              busy
);

    localparam int LEN_W   = $clog2(MAX_SYMS + 1);
    localparam int PRESC_W = $clog2(TICK_DIV);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   DUR_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   DASH_T     = CNT_W'(DASH_TICKS);
    localparam logic [CNT_W-1:0]   BKSP_T     = CNT_W'(BKSP_TICKS);
    localparam logic [CNT_W-1:0]   CHAR_T     = CNT_W'(CHAR_GAP_TICKS);
    localparam logic [CNT_W-1:0]   WORD_T     = CNT_W'(WORD_GAP_TICKS);
    localparam logic [LEN_W-1:0]   MAX_CNT    = LEN_W'(MAX_SYMS);

    localparam logic [1:0] KIND_CHAR  = 2'd0;
    localparam logic [1:0] KIND_SPACE = 2'd1;
    localparam logic [1:0] KIND_BKSP  = 2'd2;
    localparam logic [1:0] KIND_ERROR = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRESS = 3'd1,
        GAP   = 3'd2,
        EMIT  = 3'd3,
        WORD  = 3'd4
    } state_t;

    state_t               state_r, state_s;
    logic [PRESC_W-1:0]   presc_r, presc_s;
    logic [CNT_W-1:0]     dur_r, dur_s;
    logic [MAX_SYMS-1:0]  sym_buf_r, sym_buf_s;
    logic [LEN_W-1:0]     sym_cnt_r, sym_cnt_s;
    logic                 ovf_r, ovf_s;
    logic                 ret_word_r, ret_word_s;
    logic                 out_valid_r, out_valid_s;
    logic [1:0]           out_kind_r, out_kind_s;
    logic [LEN_W-1:0]     out_len_r, out_len_s;
    logic [MAX_SYMS-1:0]  out_code_r, out_code_s;
    logic                 busy_r;
    logic                 tick_s;
    logic                 is_dash_s;

    assign tick_s    = (presc_r == PRESC_LAST);
    assign is_dash_s = (dur_r >= DASH_T);

    assign out_valid = out_valid_r;
    assign out_kind  = out_kind_r;
    assign out_len   = out_len_r;
    assign out_code  = out_code_r;
    assign busy      = busy_r;

    // Next-state, timer and token-register logic of the decoder FSM.
    always_comb begin
        state_s     = state_r;
        presc_s     = presc_r;
        dur_s       = dur_r;
        sym_buf_s   = sym_buf_r;
        sym_cnt_s   = sym_cnt_r;
        ovf_s       = ovf_r;
        ret_word_s  = ret_word_r;
        out_valid_s = out_valid_r;
        out_kind_s  = out_kind_r;
        out_len_s   = out_len_r;
        out_code_s  = out_code_r;

        // Free-running prescaler; dur advances on each tick and saturates.
        if (tick_s) begin
            presc_s = {PRESC_W{1'b0}};
            if (dur_r != DUR_MAX) begin
                dur_s = dur_r + CNT_W'(1);
            end else begin
                dur_s = dur_r;
            end
        end else begin
            presc_s = presc_r + PRESC_W'(1);
        end

        case (state_r)
            IDLE: begin
                if (key) begin
                    state_s = PRESS;
                    presc_s = {PRESC_W{1'b0}};
                    dur_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end

            PRESS: begin
                if (key) begin
                    state_s = PRESS;
                end else if (dur_r >= BKSP_T) begin
                    // Long press cancels whatever was being keyed.
                    out_valid_s = 1'b1;
                    out_kind_s  = KIND_BKSP;
                    out_len_s   = {LEN_W{1'b0}};
                    out_code_s  = {MAX_SYMS{1'b0}};
                    ret_word_s  = 1'b0;
                    sym_buf_s   = {MAX_SYMS{1'b0}};
                    sym_cnt_s   = {LEN_W{1'b0}};
                    ovf_s       = 1'b0;
                    state_s     = EMIT;
                end else begin
                    if (sym_cnt_r == MAX_CNT) begin
                        ovf_s = 1'b1;
                    end else begin
                        for (int i = 0; i < MAX_SYMS; i++) begin
                            if (sym_cnt_r == LEN_W'(i)) begin
                                sym_buf_s[i] = is_dash_s;
                            end else begin
                                sym_buf_s[i] = sym_buf_r[i];
                            end
                        end
                        sym_cnt_s = sym_cnt_r + LEN_W'(1);
                    end
                    state_s = GAP;
                    presc_s = {PRESC_W{1'b0}};
                    dur_s   = {CNT_W{1'b0}};
                end
            end

            GAP: begin
                if (key) begin
                    state_s = PRESS;
                    presc_s = {PRESC_W{1'b0}};
                    dur_s   = {CNT_W{1'b0}};
                end else if (dur_r >= CHAR_T) begin
                    out_valid_s = 1'b1;
                    out_code_s  = sym_buf_r;
                    if (ovf_r) begin
                        out_kind_s = KIND_ERROR;
                        out_len_s  = MAX_CNT;
                        ret_word_s = 1'b0;
                    end else begin
                        out_kind_s = KIND_CHAR;
                        out_len_s  = sym_cnt_r;
                        ret_word_s = 1'b1;
                    end
                    state_s = EMIT;
                end else begin
                    state_s = GAP;
                end
            end

            EMIT: begin
                if (out_valid_r && out_ready) begin
                    out_valid_s = 1'b0;
                    out_kind_s  = 2'd0;
                    out_len_s   = {LEN_W{1'b0}};
                    out_code_s  = {MAX_SYMS{1'b0}};
                    sym_buf_s   = {MAX_SYMS{1'b0}};
                    sym_cnt_s   = {LEN_W{1'b0}};
                    ovf_s       = 1'b0;
                    if (ret_word_r) begin
                        state_s = WORD;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = EMIT;
                end
            end

            WORD: begin
                if (key) begin
                    state_s = PRESS;
                    presc_s = {PRESC_W{1'b0}};
                    dur_s   = {CNT_W{1'b0}};
                end else if (dur_r >= WORD_T) begin
                    // dur has been running since the last release, so a long
                    // stall in EMIT makes the space load on the first WORD cycle.
                    out_valid_s = 1'b1;
                    out_kind_s  = KIND_SPACE;
                    out_len_s   = {LEN_W{1'b0}};
                    out_code_s  = {MAX_SYMS{1'b0}};
                    ret_word_s  = 1'b0;
                    state_s     = EMIT;
                end else begin
                    state_s = WORD;
                end
            end

            default: begin
                state_s     = IDLE;
                out_valid_s = 1'b0;
                sym_buf_s   = {MAX_SYMS{1'b0}};
                sym_cnt_s   = {LEN_W{1'b0}};
                ovf_s       = 1'b0;
            end
        endcase
    end

    // State, timer, symbol buffer and output token registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            presc_r     <= {PRESC_W{1'b0}};
            dur_r       <= {CNT_W{1'b0}};
            sym_buf_r   <= {MAX_SYMS{1'b0}};
            sym_cnt_r   <= {LEN_W{1'b0}};
            ovf_r       <= 1'b0;
            ret_word_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_kind_r  <= 2'd0;
            out_len_r   <= {LEN_W{1'b0}};
            out_code_r  <= {MAX_SYMS{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            presc_r     <= presc_s;
            dur_r       <= dur_s;
            sym_buf_r   <= sym_buf_s;
            sym_cnt_r   <= sym_cnt_s;
            ovf_r       <= ovf_s;
            ret_word_r  <= ret_word_s;
            out_valid_r <= out_valid_s;
            out_kind_r  <= out_kind_s;
            out_len_r   <= out_len_s;
            out_code_r  <= out_code_s;
            busy_r      <= (state_s != IDLE);
        end
    end

endmodule
